// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide types used by the datapath and memory-side blocks.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
endpackage

// File: rtl/mem_resp_pkg.sv
// Types and constants for the datapath-to-cache responder.
package mem_resp_pkg;
   typedef enum logic [1:0] {IDLE, DACC, IACC, HALTED} resp_state_t;
   typedef enum logic {OP_READ, OP_WRITE} access_op_t;
   localparam int WAIT_CNT_W = 8;
endpackage

// File: rtl/dp_mem_responder.sv
// Serializes pipeline fetches and data accesses onto one single-ported RAM,
// returning ihit/dhit pulses and parking once the pipeline retires halt.
module dp_mem_responder
   import cpu_types_pkg::*, mem_resp_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic  CLK,
   input  logic  nRST,
   input  logic  imemREN,
   input  word_t imemaddr,
   input  logic  dmemREN,
   input  logic  dmemWEN,
   input  word_t dmemaddr,
   input  word_t dmemstore,
   input  logic  halt,
   output logic  ihit,
   output word_t imemload,
   output logic  dhit,
   output word_t dmemload,
   output logic  ramREN,
   output logic  ramWEN,
   output word_t ramaddr,
   output word_t ramstore,
   input  word_t ramload,
   input  logic  ram_ready,
   output logic  halted,
   output logic  err
);

   // err rises on the edge that ends the TIMEOUT-th wait cycle.
   localparam logic [WAIT_CNT_W-1:0] ERR_AT = WAIT_CNT_W'(TIMEOUT - 1);

   resp_state_t            state;
   access_op_t             op_q;
   word_t                  addr_q;
   word_t                  store_q;
   logic [WAIT_CNT_W-1:0]  wait_cnt;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge CLK) begin
      // NOTE: reset is synchronous, so it lives inside the clocked branch and
      // only takes effect at an edge.
      if (!nRST) begin
         state    <= IDLE;
         op_q     <= OP_READ;
         addr_q   <= '0;
         store_q  <= '0;
         wait_cnt <= '0;
         halted   <= 1'b0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (halt) begin
                  state  <= HALTED;
                  halted <= 1'b1;
               end else if (dmemREN || dmemWEN) begin
                  addr_q   <= dmemaddr;
                  store_q  <= dmemstore;
                  op_q     <= dmemWEN ? OP_WRITE : OP_READ;
                  wait_cnt <= '0;
                  state    <= DACC;
               end else if (imemREN) begin
                  addr_q   <= imemaddr;
                  op_q     <= OP_READ;
                  wait_cnt <= '0;
                  state    <= IACC;
               end
            end
            DACC: begin
               if (ram_ready) begin
                  state <= IDLE;
               end else if (op_q == OP_READ && (!dmemREN || dmemaddr != addr_q)) begin
                  state <= IDLE;
               end
            end
            IACC: begin
               if (ram_ready || !imemREN || imemaddr != addr_q) begin
                  state <= IDLE;
               end
            end
            HALTED: state <= HALTED;
            default: state <= IDLE;
         endcase

         if ((state == DACC || state == IACC) && !ram_ready) begin
            if (wait_cnt != '1) begin
               wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_cnt >= ERR_AT) begin
               err <= 1'b1;
            end
         end
      end
   end

   // Strobes and hits decode directly from state so a hit can land the same
   // cycle ram_ready arrives.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      ihit     = 1'b0;
      dhit     = 1'b0;
      imemload = '0;
      dmemload = '0;
      case (state)
         DACC: begin
            ramaddr = addr_q;
            ramREN  = (op_q == OP_READ);
            ramWEN  = (op_q == OP_WRITE);
            if (op_q == OP_WRITE) begin
               ramstore = store_q;
            end
            if (ram_ready) begin
               dhit = 1'b1;
               if (op_q == OP_READ) begin
                  dmemload = ramload;
               end
            end
         end
         IACC: begin
            ramaddr = addr_q;
            ramREN  = 1'b1;
            if (ram_ready) begin
               ihit     = 1'b1;
               imemload = ramload;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dp_mem_responder.sv
// Randomized bench for dp_mem_responder against a transaction-level memory model.
module tb_dp_mem_responder;
   import cpu_types_pkg::*;

   localparam int TMO = 4;

   logic  CLK = 1'b0;
   logic  nRST = 1'b0;
   logic  imemREN = 1'b0, dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0;
   word_t imemaddr = '0, dmemaddr = '0, dmemstore = '0;
   logic  ihit, dhit, ramREN, ramWEN, halted, err;
   word_t imemload, dmemload, ramaddr, ramstore;
   word_t ramload = '0;
   logic  ram_ready = 1'b0;

   int checks = 0;
   int errors = 0;
   bit err_sticky = 1'b0;

   // ram_mem is what the RAM really holds (written from DUT strobes);
   // ref_mem is what the pipeline expects from the completed transactions.
   word_t ram_mem [0:255];
   word_t ref_mem [0:255];

   dp_mem_responder #(.TIMEOUT(TMO)) dut (
      .CLK(CLK), .nRST(nRST),
      .imemREN(imemREN), .imemaddr(imemaddr),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .halt(halt),
      .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ram_ready(ram_ready),
      .halted(halted), .err(err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_check(input string tag);
      check(tag, 32'({ramREN, ramWEN, ihit, dhit}), 32'd0);
   endtask

   task automatic release_all();
      imemREN = 1'b0;
      dmemREN = 1'b0;
      dmemWEN = 1'b0;
      ram_ready = 1'b0;
   endtask

   // RAM side for one cycle: present data for the address the DUT drives.
   task automatic ram_cycle(input bit ready);
      ram_ready = ready;
      ramload = ready ? ram_mem[ramaddr[9:2]] : word_t'($urandom);
      #1;
      if (ready && ramWEN) begin
         ram_mem[ramaddr[9:2]] = ramstore;
      end
   endtask

   // One complete access with ram_ready arriving on access cycle 'delay'.
   task automatic access(input bit is_fetch, input bit is_write, input word_t addr,
                         input word_t data, input int delay, input bit drop_store);
      bit hit;
      tick();
      if (is_fetch) begin
         imemREN = 1'b1;
         imemaddr = addr;
      end else begin
         dmemREN = !is_write;
         dmemWEN = is_write;
         dmemaddr = addr;
         dmemstore = data;
      end
      ram_ready = 1'b0;
      #1;
      idle_check("req_idle");
      for (int i = 0; i <= delay; i++) begin
         tick();
         if (is_write && drop_store && i == 0) begin
            dmemWEN = 1'b0;
         end
         hit = (i == delay);
         ram_cycle(hit);
         check("ramaddr", ramaddr, addr);
         check("ramREN", 32'(ramREN), 32'(!is_write));
         check("ramWEN", 32'(ramWEN), 32'(is_write));
         if (is_write) check("ramstore", ramstore, data);
         check("ihit", 32'(ihit), 32'(is_fetch && hit));
         check("dhit", 32'(dhit), 32'(!is_fetch && hit));
         check("err", 32'(err), 32'(err_sticky || i >= TMO));
         if (hit) begin
            if (is_fetch)      check("imemload", imemload, ref_mem[addr[9:2]]);
            else if (is_write) check("dmemload_st", dmemload, 32'd0);
            else               check("dmemload", dmemload, ref_mem[addr[9:2]]);
            if (is_write) ref_mem[addr[9:2]] = data;
         end
      end
      if (delay >= TMO) err_sticky = 1'b1;
      tick();
      release_all();
      #1;
      idle_check("gap_idle");
   endtask

   initial begin
      int kind, dly;
      word_t a, d;

      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = word_t'($urandom);
         ref_mem[i] = ram_mem[i];
      end

      // Reset state
      tick();
      tick();
      #1;
      check("rst_strobes", 32'({ramREN, ramWEN, ihit, dhit, halted, err}), 32'd0);
      check("rst_ramaddr", ramaddr, 32'd0);
      check("rst_loads", imemload | dmemload, 32'd0);
      nRST = 1'b1;

      // Randomized mix of fetches, loads and stores
      for (int n = 0; n < 60; n++) begin
         kind = int'($urandom_range(0, 2));
         dly  = int'($urandom_range(0, 2));
         a    = (word_t'($urandom_range(0, 255)) << 2) | word_t'($urandom_range(0, 3));
         d    = word_t'($urandom);
         access(kind == 0, kind == 2, a, d, dly, bit'($urandom_range(0, 1)));
      end

      // Fetch only
      ram_mem[16] = 32'h2001_0005;
      ref_mem[16] = 32'h2001_0005;
      access(1'b1, 1'b0, 32'h0000_0040, '0, 3, 1'b0);

      // Simultaneous request: data first, one IDLE, then the fetch
      ram_mem[64] = 32'hDEAD_BEEF;
      ref_mem[64] = 32'hDEAD_BEEF;
      tick();
      imemREN = 1'b1; imemaddr = 32'h44;
      dmemREN = 1'b1; dmemaddr = 32'h100;
      #1;
      idle_check("sim_idle0");
      tick();
      ram_cycle(1'b1);
      check("sim_daddr", ramaddr, 32'h100);
      check("sim_hits", 32'({ihit, dhit}), 32'b01);
      check("sim_dload", dmemload, 32'hDEAD_BEEF);
      tick();
      dmemREN = 1'b0;
      ram_ready = 1'b0;
      #1;
      idle_check("sim_idle1");
      tick();
      ram_cycle(1'b1);
      check("sim_iaddr", ramaddr, 32'h44);
      check("sim_ihits", 32'({ihit, dhit}), 32'b10);
      check("sim_iload", imemload, ref_mem[17]);
      tick();
      release_all();
      #1;
      idle_check("sim_gap");

      // Store completes although dmemWEN drops, then read it back
      access(1'b0, 1'b1, 32'h200, 32'h1234_5678, 3, 1'b1);
      access(1'b0, 1'b0, 32'h200, '0, 1, 1'b0);

      // Fetch redirect: abandoned without ihit, new address fetched next
      tick();
      imemREN = 1'b1; imemaddr = 32'h80;
      #1;
      idle_check("rd_idle0");
      tick();
      ram_cycle(1'b0);
      check("rd_addr0", ramaddr, 32'h80);
      tick();
      imemaddr = 32'h300;
      ram_cycle(1'b0);
      check("rd_nohit", 32'({ihit, dhit}), 32'd0);
      tick();
      #1;
      idle_check("rd_idle1");
      tick();
      ram_cycle(1'b1);
      check("rd_addr1", ramaddr, 32'h300);
      check("rd_ihit", 32'(ihit), 32'd1);
      check("rd_iload", imemload, ref_mem[192]);
      tick();
      release_all();
      #1;

      // Load abort when dmemREN drops
      tick();
      dmemREN = 1'b1; dmemaddr = 32'h10;
      #1;
      tick();
      ram_cycle(1'b0);
      check("la_ren", 32'(ramREN), 32'd1);
      tick();
      dmemREN = 1'b0;
      ram_cycle(1'b0);
      check("la_nohit", 32'(dhit), 32'd0);
      tick();
      #1;
      idle_check("la_idle");

      // Timeout: err after the 4th wait, access still completes, err sticky
      access(1'b0, 1'b0, 32'h20, '0, 6, 1'b0);
      access(1'b1, 1'b0, 32'h24, '0, 0, 1'b0);

      // Reset mid-DACC drops the access and clears err
      tick();
      dmemREN = 1'b1; dmemaddr = 32'h30;
      #1;
      tick();
      ram_cycle(1'b0);
      check("mr_dacc", 32'(ramREN), 32'd1);
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      release_all();
      #1;
      check("mr_outs", 32'({ramREN, ramWEN, ihit, dhit, halted, err}), 32'd0);
      check("mr_addr", ramaddr, 32'd0);
      err_sticky = 1'b0;
      access(1'b0, 1'b0, 32'h34, '0, 0, 1'b0);

      // Halt parks the responder; requests ignored until reset
      tick();
      halt = 1'b1;
      #1;
      idle_check("h_idle");
      tick();
      halt = 1'b0;
      imemREN = 1'b1; imemaddr = 32'h50;
      #1;
      check("h_halted", 32'(halted), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         ram_cycle(1'b1);
         idle_check("h_ignored");
      end
      release_all();
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      #1;
      check("h_reset", 32'(halted), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dp_mem_responder.md
Name: dp_mem_responder

Overview:
- Responder (cache/memory side) of the datapath-to-cache request interface.
- Accepts instruction fetches and data loads/stores from the pipeline and serializes them onto one single-ported RAM.
- Returns ihit/dhit with load data, and parks in a halted state once the pipeline retires halt.
- Sits between the datapath and the RAM model, replacing the dummy pass-through used for single-cycle bring-up.

Parameters:
- TIMEOUT, 64: RAM wait cycles without ram_ready before the sticky err flag sets; legal range 2..255.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  synchronous active-low reset.
- imemREN  input  1  instruction fetch request.
- imemaddr  input  32  fetch address, word aligned.
- dmemREN  input  1  data load request.
- dmemWEN  input  1  data store request; never asserted together with dmemREN.
- dmemaddr  input  32  data address.
- dmemstore  input  32  store data.
- halt  input  1  pipeline retired halt.
- ihit  output  1  fetch complete; one-cycle pulse.
- imemload  output  32  fetched instruction; valid only while ihit=1.
- dhit  output  1  data access complete; one-cycle pulse.
- dmemload  output  32  load data; valid only while dhit=1 on a load.
- ramREN  output  1  RAM read strobe.
- ramWEN  output  1  RAM write strobe.
- ramaddr  output  32  RAM address.
- ramstore  output  32  RAM write data.
- ramload  input  32  RAM read data.
- ram_ready  input  1  RAM access complete this cycle.
- halted  output  1  responder parked.
- err  output  1  sticky RAM timeout flag.

Behaviour:
- Clocking and reset: one clock CLK; nRST is synchronous and active-low.
- State after nRST=0 at an edge:
  - state=IDLE, latched addr/data=0, wait counter=0, err=0, halted=0.
  - All RAM strobes and hits are 0, and the load outputs are 0.
  - Reset mid-access drops the access at that edge; a partial RAM write is the RAM's concern.
- States: IDLE, DACC, IACC, HALTED.
- IDLE:
  - If halt=1, go to HALTED.
  - Else if dmemREN or dmemWEN, latch dmemaddr, dmemstore and the op, then go to DACC. Data has priority over fetch.
  - Else if imemREN, latch imemaddr and go to IACC.
  - Else stay in IDLE.
  - No RAM strobes are driven in IDLE.
- DACC:
  - Drive ramaddr and ramstore from the latches; ramREN or ramWEN per the latched op.
  - When ram_ready=1: dhit=1 that same cycle, dmemload=ramload for loads (0 for stores), next state IDLE.
  - Load abort: if dmemREN drops, or dmemaddr no longer equals the latched address, before ram_ready, go to IDLE with no dhit.
  - Stores never abort; they always complete and pulse dhit.
- IACC:
  - Drive ramREN=1 and ramaddr from the latch.
  - When ram_ready=1: ihit=1 and imemload=ramload that cycle, next state IDLE.
  - Abort: if imemREN=0, or imemaddr differs from the latch (branch/jump redirect), go to IDLE with no ihit. The new address is arbitrated the following cycle.
  - A data request arriving mid-IACC waits; the fetch is not preempted.
- Latency:
  - Request seen in IDLE at cycle 0; earliest hit in cycle 1.
  - Hits are combinational from state and ram_ready.
  - At least one IDLE cycle separates consecutive accesses. Back-to-back requests therefore complete no faster than every 2 cycles.
- ihit and dhit are never both 1. A held request after a hit is treated as a new access.
- Timeout:
  - The wait counter clears on entry to DACC/IACC and increments each ram_ready=0 cycle.
  - When it reaches TIMEOUT, err sets and stays set until reset.
  - The access keeps waiting after err sets; it is not aborted.
- HALTED:
  - No strobes, no hits; halted=1; requests are ignored.
  - Exit only via reset.
  - halt arriving mid-access is honoured only after returning to IDLE, so an in-flight store completes first.
- Address bits [1:0] pass through unchanged; no alignment checking.

Decomposition:
- Package mem_resp_pkg:
  - typedef enum logic [1:0] resp_state_t {IDLE, DACC, IACC, HALTED}.
  - typedef enum logic access_op_t {OP_READ, OP_WRITE}.
  - Constant WAIT_CNT_W = 8.
- Reuse word_t from cpu_types_pkg.
- No sub-module is needed. The wait counter and timeout compare stay inline.

Test Plan:
1. Fetch only: imemREN=1, imemaddr=0x0000_0040, RAM ready 3 cycles after IACC entry with ramload=0x2001_0005 -> ramREN=1, ramaddr=0x40 in IACC; single ihit pulse, imemload=0x2001_0005; dhit=0 throughout.
2. Simultaneous request: imemREN=1 at 0x44, dmemREN=1 at 0x100, ramload=0xDEAD_BEEF -> DACC first, dhit with dmemload=0xDEAD_BEEF; then IDLE, then IACC for 0x44, then ihit.
3. Store completes despite drop: dmemWEN=1, dmemaddr=0x200, dmemstore=0x1234_5678; dmemWEN drops one cycle later; ram_ready after 4 cycles -> ramWEN held with ramaddr=0x200, ramstore=0x1234_5678 until ready; dhit pulses.
4. Fetch redirect: IACC on 0x80, imemaddr changes to 0x300 before ram_ready -> no ihit; IDLE for one cycle; new IACC with ramaddr=0x300.
5. Timeout: TIMEOUT=4, ram_ready held 0 in DACC -> err=1 after the 4th wait cycle; ready on cycle 7 -> dhit; err stays 1 until nRST=0.
6. Halt and reset: halt=1 in IDLE -> halted=1, imemREN ignored; nRST=0 for one edge mid-DACC -> all outputs 0 and state IDLE the next cycle.
